// File: rtl/bist_pkg.sv
// Shared state encoding and datapath constants for the BIST sequencer.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4,
    DONE    = 3'd5
  } bist_state_e;

  // Width of the scan_in pattern LFSR seeded by reset_internal.
  localparam int LFSR_SEED_W = 26;

endpackage

// File: rtl/bist_counter.sv
// Up-counter with synchronous clear, enable and terminal-count flag; saturates at all-ones.
module bist_counter
#(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 15
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

  assign terminal = (count == TC_VAL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: seeds the pattern LFSR, shifts/captures N_PATTERNS through the scan chain,
// unloads into the MISR and reports done/pass. Optional watchdog under BIST_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start
// INIT    | seed LFSR, clear MISR and counters
// SHIFT   | load one pattern into the chain, compacting scan_out
// CAPTURE | one functional capture cycle
// UNLOAD  | shift out the final response
// DONE    | result held until restart
module bist_controller
  import bist_pkg::*;
#(
  parameter int                   CHAIN_LEN  = 32,
  parameter int                   N_PATTERNS = 1000,
  parameter int                   SIG_WIDTH  = 16,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = '0
)
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 reset_internal,
  output logic                 control_state,
  output logic                 scan_en,
  output logic                 test_mode,
  output logic                 misr_en,
  input  logic [SIG_WIDTH-1:0] misr_signature,
  output logic                 busy,
  output logic                 done,
  output logic                 pass
`ifdef BIST_TIMEOUT_EN
  ,
  output logic                 timeout
`endif
);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_INIT    = INIT;
  localparam logic [2:0] ST_SHIFT   = SHIFT;
  localparam logic [2:0] ST_CAPTURE = CAPTURE;
  localparam logic [2:0] ST_UNLOAD  = UNLOAD;
  localparam logic [2:0] ST_DONE    = DONE;

  localparam int BIT_W = $clog2(CHAIN_LEN);
  localparam int PAT_W = $clog2(N_PATTERNS + 1);

  logic [2:0]       state, state_nxt;
  logic             shifting;
  logic [BIT_W-1:0] bit_cnt;
  logic [PAT_W-1:0] pat_cnt;
  logic             bit_tc, pat_tc;
  logic             unused_cnt;

  assign shifting       = (state == ST_SHIFT) || (state == ST_UNLOAD);
  assign reset_internal = (state == ST_INIT);
  assign control_state  = shifting;
  assign scan_en        = shifting;
  assign misr_en        = shifting;
  assign busy           = (state == ST_INIT) || (state == ST_SHIFT) ||
                          (state == ST_CAPTURE) || (state == ST_UNLOAD);
  assign test_mode      = busy;
  assign done           = (state == ST_DONE);

  // bit_cnt paces both the per-pattern shift and the final unload.
  bist_counter #(.WIDTH(BIT_W), .TERMINAL(CHAIN_LEN - 1)) u_bit_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    ((state == ST_INIT) || (shifting && bit_tc)),
    .enable   (shifting),
    .count    (bit_cnt),
    .terminal (bit_tc)
  );

  bist_counter #(.WIDTH(PAT_W), .TERMINAL(N_PATTERNS - 1)) u_pat_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (state == ST_INIT),
    .enable   (state == ST_CAPTURE),
    .count    (pat_cnt),
    .terminal (pat_tc)
  );

  // Count values are only needed through their terminal flags.
  assign unused_cnt = ^{bit_cnt, pat_cnt};

`ifdef BIST_TIMEOUT_EN
  localparam int WDG_LIMIT = 1 + N_PATTERNS * (CHAIN_LEN + 1) + CHAIN_LEN + 8;
  localparam int WDG_W     = $clog2(WDG_LIMIT + 1);

  logic [WDG_W-1:0] wdg_cnt;
  logic             wdg_tc;
  logic             unused_wdg;
  logic             wdg_fire;

  bist_counter #(.WIDTH(WDG_W), .TERMINAL(WDG_LIMIT - 1)) u_wdg_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (!busy),
    .enable   (busy),
    .count    (wdg_cnt),
    .terminal (wdg_tc)
  );

  assign unused_wdg = ^wdg_cnt;
  assign wdg_fire   = busy && wdg_tc;
`endif

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:    state_nxt = start  ? ST_INIT   : ST_IDLE;
      ST_INIT:    state_nxt = ST_SHIFT;
      ST_SHIFT:   state_nxt = bit_tc ? ST_CAPTURE : ST_SHIFT;
      ST_CAPTURE: state_nxt = pat_tc ? ST_UNLOAD : ST_SHIFT;
      ST_UNLOAD:  state_nxt = bit_tc ? ST_DONE   : ST_UNLOAD;
      ST_DONE:    state_nxt = start  ? ST_INIT   : ST_DONE;
      default:    state_nxt = ST_IDLE;
    endcase
`ifdef BIST_TIMEOUT_EN
    if (wdg_fire)
      state_nxt = ST_DONE;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Signature is sampled on the edge that follows the last compaction cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pass <= 1'b0;
    else if (state_nxt == ST_INIT)
      pass <= 1'b0;
`ifdef BIST_TIMEOUT_EN
    else if (wdg_fire)
      pass <= 1'b0;
`endif
    else if ((state == ST_UNLOAD) && bit_tc)
      pass <= (misr_signature == GOLDEN_SIG);
  end

`ifdef BIST_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      timeout <= 1'b0;
    else if (state_nxt == ST_INIT)
      timeout <= 1'b0;
    else if (wdg_fire)
      timeout <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller (CHAIN_LEN=4, N_PATTERNS=3, GOLDEN_SIG=16'hBEEF).
module tb_bist_controller;

  localparam int          CL   = 4;
  localparam int          NP   = 3;
  localparam logic [15:0] GOLD = 16'hBEEF;
  localparam int          LAT  = 20;

  typedef struct {
    int   lat;
    logic pass;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic        reset_internal;
  logic        control_state;
  logic        scan_en;
  logic        test_mode;
  logic        misr_en;
  logic [15:0] misr_signature;
  logic        busy;
  logic        done;
  logic        pass;
`ifdef BIST_TIMEOUT_EN
  logic        timeout;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  bist_controller #(
    .CHAIN_LEN  (CL),
    .N_PATTERNS (NP),
    .SIG_WIDTH  (16),
    .GOLDEN_SIG (GOLD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .reset_internal (reset_internal),
    .control_state  (control_state),
    .scan_en        (scan_en),
    .test_mode      (test_mode),
    .misr_en        (misr_en),
    .misr_signature (misr_signature),
    .busy           (busy),
    .done           (done),
    .pass           (pass)
`ifdef BIST_TIMEOUT_EN
    ,
    .timeout        (timeout)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {reset_internal, control_state, scan_en, test_mode, misr_en, busy, done}, m cycles after start sample
  function automatic logic [6:0] exp_outs(input int m);
    int j;
    if (m == 0) return 7'b1001010;
    j = m - 1;
    if (j < NP * (CL + 1)) begin
      if ((j % (CL + 1)) < CL) return 7'b0111110;
      return 7'b0001010;
    end
    if (j < NP * (CL + 1) + CL) return 7'b0111110;
    return 7'b0000001;
  endfunction

  // Entered at the negedge right after the start sample (DUT in INIT); returns at the first done cycle.
  task automatic run_body(input logic [15:0] target, output int cs_cnt, output int gap_cnt);
    int         m;
    bit         finished;
    logic [6:0] obs;
    logic [6:0] exp;
    exp_t       e;
    m = 0; cs_cnt = 0; gap_cnt = 0; finished = 0;
    misr_signature = target ^ 16'h0001;
    while (!finished && m <= 40) begin
      obs = {reset_internal, control_state, scan_en, test_mode, misr_en, busy, done};
      exp = exp_outs(m);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %b expected %b", m, obs, exp);
      end
      if (control_state === 1'b1) cs_cnt++;
      if (busy === 1'b1 && scan_en === 1'b0 && reset_internal === 1'b0) gap_cnt++;
      if (done === 1'b1) begin
        finished = 1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: done with no expected entry");
        end else begin
          e = exp_q.pop_front();
          if (m != e.lat) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d", m, e.lat);
          end
          checks++;
          if (pass !== e.pass) begin
            errors++;
            $display("FAIL pass: got %b expected %b (sig %h)", pass, e.pass, target);
          end
        end
      end else begin
        checks++;
        if (pass !== 1'b0) begin
          errors++;
          $display("FAIL pass_during_run cycle %0d: got %b expected 0", m, pass);
        end
        if (m == LAT - 1) misr_signature = target;
        @(negedge clock);
        m++;
      end
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles", m);
    end
  endtask

  task automatic start_run(input logic [15:0] target, output int cs_cnt, output int gap_cnt);
    @(negedge clock);
    start = 1'b1;
    exp_q.push_back('{lat: LAT, pass: (target == GOLD)});
    @(negedge clock);
    start = 1'b0;
    run_body(target, cs_cnt, gap_cnt);
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    reset = 1'b1; start = 1'b0; misr_signature = GOLD;
    repeat (2) @(negedge clock);
    obs = {reset_internal, control_state, scan_en, test_mode, misr_en, busy, done, pass};
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000", obs);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    logic [7:0] obs;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      obs = {reset_internal, control_state, scan_en, test_mode, misr_en, busy, done, pass};
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL idle_outputs: got %b expected 00000000", obs);
      end
    end
  endtask

  task automatic test_pass_run();
    int cs, gp;
    start_run(GOLD, cs, gp);
    checks++;
    if (cs != 16) begin
      errors++;
      $display("FAIL shift_cycles: got %0d expected 16", cs);
    end
    checks++;
    if (gp != 3) begin
      errors++;
      $display("FAIL capture_gaps: got %0d expected 3", gp);
    end
  endtask

  task automatic test_fail_run();
    int cs, gp;
    start_run(16'hBEEE, cs, gp);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b1 || pass !== 1'b0) begin
        errors++;
        $display("FAIL done_hold: got done=%b pass=%b expected done=1 pass=0", done, pass);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] obs;
    int         cs, gp;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    checks++;
    if (scan_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL second_shift: got scan_en=%b busy=%b expected 1 1", scan_en, busy);
    end
    #1 reset = 1'b1;
    #1;
    obs = {reset_internal, control_state, scan_en, test_mode, misr_en, busy, done, pass};
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL async_abort: got %b expected 00000000", obs);
    end
    @(negedge clock);
    reset = 1'b0;
    start_run(GOLD, cs, gp);
  endtask

  task automatic test_start_held();
    int cs, gp;
    @(negedge clock);
    start = 1'b1;
    exp_q.push_back('{lat: LAT, pass: 1'b1});
    @(negedge clock);
    run_body(GOLD, cs, gp);
    exp_q.push_back('{lat: LAT, pass: 1'b0});
    @(negedge clock);
    checks++;
    if (reset_internal !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL held_restart: got reset_internal=%b done=%b expected 1 0", reset_internal, done);
    end
    run_body(16'h1234, cs, gp);
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL held_release: got done=%b expected 1", done);
    end
  endtask

  task automatic test_back_to_back();
    int          cs, gp;
    logic [15:0] sig;
    for (int i = 0; i < 3; i++) begin
      sig = (i == 1) ? GOLD : 16'($urandom_range(0, 16'hFFFF));
      start_run(sig, cs, gp);
    end
  endtask

`ifdef BIST_TIMEOUT_EN
  task automatic test_timeout();
    int m, cs, gp;
    bit fin;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    force dut.bit_tc = 1'b0;
    m = 1; fin = 0;
    while (!fin && m < 60) begin
      if (done === 1'b1) fin = 1;
      else begin
        @(negedge clock);
        m++;
      end
    end
    release dut.bit_tc;
    checks++;
    if (!fin || m != 28) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected 28", m);
    end
    checks++;
    if (timeout !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flag: got timeout=%b pass=%b expected 1 0", timeout, pass);
    end
    start_run(GOLD, cs, gp);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b expected 0", timeout);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    misr_signature = 16'h0000;
    test_reset();
    test_idle();
    test_pass_run();
    test_fail_run();
    test_reset_abort();
    test_start_held();
    test_back_to_back();
`ifdef BIST_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
